// File: rtl/stopwatch_bcd_if.sv
// rtl/stopwatch_bcd_if.sv - control and BCD display signals of the stopwatch
interface stopwatch_bcd_if;
    logic        tick_in;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic        running;
    logic [7:0]  cs_bcd;
    logic [7:0]  sec_bcd;
    logic [7:0]  min_bcd;
    logic        wrap;
    logic [23:0] lap_bcd;
    logic        lap_valid;

    modport master (
        output tick_in, start_stop, clear, lap,
        input  running, cs_bcd, sec_bcd, min_bcd, wrap, lap_bcd, lap_valid
    );

    modport slave (
        input  tick_in, start_stop, clear, lap,
        output running, cs_bcd, sec_bcd, min_bcd, wrap, lap_bcd, lap_valid
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - BCD MM:SS.CC stopwatch counting rising edges of a 100 Hz tick
// Optional lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd #(
    parameter int MIN_MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_bcd_if.slave   sw
);
    localparam logic [3:0] MIN_MAX_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_MAX_U = 4'(MIN_MAX % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t     state, state_nxt;
    logic       tick_q;
    logic       tick_edge;
    logic       count_en;
    logic       running_q;
    logic       wrap_q, wrap_nxt;
    logic [3:0] cs_t, cs_u, sec_t, sec_u, min_t, min_u;
    logic [3:0] cs_t_nxt, cs_u_nxt, sec_t_nxt, sec_u_nxt, min_t_nxt, min_u_nxt;

    assign tick_edge = sw.tick_in & ~tick_q;
    assign count_en  = (state == RUN) && tick_edge && !sw.clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_q    <= sw.tick_in;
            running_q <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        if (sw.clear) begin
            state_nxt = IDLE;
        end else if (sw.start_stop) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Ripple carry through the BCD digits; each nibble rolls over at its own limit.
    always_comb begin
        cs_u_nxt  = cs_u;
        cs_t_nxt  = cs_t;
        sec_u_nxt = sec_u;
        sec_t_nxt = sec_t;
        min_u_nxt = min_u;
        min_t_nxt = min_t;
        wrap_nxt  = 1'b0;
        if (count_en) begin
            if (cs_u != 4'd9) begin
                cs_u_nxt = cs_u + 4'd1;
            end else begin
                cs_u_nxt = 4'd0;
                if (cs_t != 4'd9) begin
                    cs_t_nxt = cs_t + 4'd1;
                end else begin
                    cs_t_nxt = 4'd0;
                    if (sec_u != 4'd9) begin
                        sec_u_nxt = sec_u + 4'd1;
                    end else begin
                        sec_u_nxt = 4'd0;
                        if (sec_t != 4'd5) begin
                            sec_t_nxt = sec_t + 4'd1;
                        end else begin
                            sec_t_nxt = 4'd0;
                            if (min_t == MIN_MAX_T && min_u == MIN_MAX_U) begin
                                min_t_nxt = 4'd0;
                                min_u_nxt = 4'd0;
                                wrap_nxt  = 1'b1;
                            end else if (min_u != 4'd9) begin
                                min_u_nxt = min_u + 4'd1;
                            end else begin
                                min_u_nxt = 4'd0;
                                min_t_nxt = min_t + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sw.clear) begin
            cs_u   <= 4'd0;
            cs_t   <= 4'd0;
            sec_u  <= 4'd0;
            sec_t  <= 4'd0;
            min_u  <= 4'd0;
            min_t  <= 4'd0;
            wrap_q <= 1'b0;
        end else begin
            cs_u   <= cs_u_nxt;
            cs_t   <= cs_t_nxt;
            sec_u  <= sec_u_nxt;
            sec_t  <= sec_t_nxt;
            min_u  <= min_u_nxt;
            min_t  <= min_t_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign sw.running = running_q;
    assign sw.wrap    = wrap_q;
    assign sw.cs_bcd  = {cs_t, cs_u};
    assign sw.sec_bcd = {sec_t, sec_u};
    assign sw.min_bcd = {min_t, min_u};

`ifdef STOPWATCH_LAP_EN
    logic [23:0] lap_q;
    logic        lap_valid_q;

    // Captures the digits as they stand before this edge's increment.
    always_ff @(posedge clk) begin
        if (rst || sw.clear) begin
            lap_q       <= 24'd0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_valid_q <= sw.lap && (state != IDLE);
            if (sw.lap && (state != IDLE))
                lap_q <= {min_t, min_u, sec_t, sec_u, cs_t, cs_u};
        end
    end

    assign sw.lap_bcd   = lap_q;
    assign sw.lap_valid = lap_valid_q;
`else
    logic lap_unused;
    assign lap_unused   = sw.lap;
    assign sw.lap_bcd   = 24'd0;
    assign sw.lap_valid = 1'b0;
`endif
endmodule
